// File: rtl/ks_program_loader.sv
// Program RAM and boot loader for the K&S core.
// It fills the RAM from a valid/ready host stream, then releases the core to read and write it.
module ks_program_loader #(
  parameter  int DEPTH = 32,
  parameter  int WIDTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  output logic             load_ready,
  input  logic             load_restart,
  output logic [CW-1:0]    load_count,
  output logic             core_run,
  input  logic [AW-1:0]    ram_addr,
  input  logic             ram_write_enable,
  input  logic [WIDTH-1:0] core_wdata,
  output logic [WIDTH-1:0] core_rdata
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] rdata_reg;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             accept;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;

  // A restart in the same cycle as a beat drops the beat.
  assign accept = (state_reg == LOAD) && load_valid && !load_restart;

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    case (state_reg)
      IDLE: begin
        state_next = LOAD;
        count_next = '0;
      end
      LOAD: begin
        if (load_restart) begin
          count_next = '0;
        end else if (load_valid) begin
          count_next = count_reg + CW'(1);
          if (load_last || (count_reg == CW'(DEPTH - 1)))
            state_next = RUN;
        end
      end
      RUN: begin
        if (load_restart) begin
          state_next = LOAD;
          count_next = '0;
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  // Loader and core never write in the same state, so one shared write port suffices.
  assign mem_we    = !rst && (accept || ((state_reg == RUN) && ram_write_enable));
  assign mem_waddr = (state_reg == RUN) ? ram_addr : count_reg[AW-1:0];
  assign mem_wdata = (state_reg == RUN) ? core_wdata : load_data;

  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_waddr] <= mem_wdata;
  end

  // Registered read, read-before-write; forced to zero whenever the core is not running.
  always_ff @(posedge clk) begin
    if (rst)
      rdata_reg <= '0;
    else if ((state_reg == RUN) && !load_restart)
      rdata_reg <= mem[ram_addr];
    else
      rdata_reg <= '0;
  end

  assign load_ready = (state_reg == LOAD);
  assign core_run   = (state_reg == RUN);
  assign load_count = count_reg;
  assign core_rdata = rdata_reg;

endmodule

// File: tb/tb_ks_program_loader.sv
// Bench for ks_program_loader.
// It runs directed loads, reads and restarts, then random traffic, all checked against an abstract model.
module tb_ks_program_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic [15:0] load_data = '0;
  logic        load_last = 1'b0;
  logic        load_ready;
  logic        load_restart = 1'b0;
  logic [5:0]  load_count;
  logic        core_run;
  logic [4:0]  ram_addr = '0;
  logic        ram_write_enable = 1'b0;
  logic [15:0] core_wdata = '0;
  logic [15:0] core_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ks_program_loader dut (
    .clk              (clk),
    .rst              (rst),
    .load_valid       (load_valid),
    .load_data        (load_data),
    .load_last        (load_last),
    .load_ready       (load_ready),
    .load_restart     (load_restart),
    .load_count       (load_count),
    .core_run         (core_run),
    .ram_addr         (ram_addr),
    .ram_write_enable (ram_write_enable),
    .core_wdata       (core_wdata),
    .core_rdata       (core_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Abstract model: a mode, a word counter, and a RAM image with a per-word known flag.
  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_RUN  = 2;
  int          m_mode = M_IDLE;
  int          m_count = 0;
  logic [15:0] m_mem [32];
  bit          m_known [32];
  logic [15:0] m_rdata = '0;
  bit          m_rknown = 1'b1;
  bit          m_init = 1'b0;

  always @(posedge clk) begin
    logic [15:0] old_word;
    bit          old_known;
    if (rst) begin
      m_init   = 1'b1;
      m_mode   = M_IDLE;
      m_count  = 0;
      m_rdata  = '0;
      m_rknown = 1'b1;
    end else if (m_mode == M_IDLE) begin
      m_mode  = M_LOAD;
      m_count = 0;
      m_rdata = '0;
      m_rknown = 1'b1;
    end else if (m_mode == M_LOAD) begin
      m_rdata  = '0;
      m_rknown = 1'b1;
      if (load_restart) begin
        m_count = 0;
      end else if (load_valid) begin
        m_mem[m_count]   = load_data;
        m_known[m_count] = 1'b1;
        m_count++;
        if (load_last || m_count == 32) m_mode = M_RUN;
      end
    end else begin
      old_word  = m_mem[ram_addr];
      old_known = m_known[ram_addr];
      if (ram_write_enable) begin
        m_mem[ram_addr]   = core_wdata;
        m_known[ram_addr] = 1'b1;
      end
      if (load_restart) begin
        m_mode   = M_LOAD;
        m_count  = 0;
        m_rdata  = '0;
        m_rknown = 1'b1;
      end else begin
        m_rdata  = old_word;
        m_rknown = old_known;
      end
    end
  end

  // Continuous comparison, half a cycle away from the active edge.
  always @(negedge clk) begin
    if (m_init) begin
      chk("load_ready", 32'(load_ready), 32'(m_mode == M_LOAD));
      chk("core_run",   32'(core_run),   32'(m_mode == M_RUN));
      chk("load_count", 32'(load_count), 32'(m_count));
      if (m_rknown) chk("core_rdata", 32'(core_rdata), 32'(m_rdata));
    end
  end

  task automatic send(input logic [15:0] d, input bit last);
    int t = 0;
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    while (!load_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("send_timeout", 32'(load_ready), 32'd1);
    @(negedge clk);
    $display("send data=0x%04h last=%0d count=%0d", d, last, load_count);
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [15:0] e);
    ram_addr = a;
    @(negedge clk);
    $display("read addr=%0d data=0x%04h", a, core_rdata);
    chk($sformatf("read_addr%0d", a), 32'(core_rdata), 32'(e));
  endtask

  task automatic restart();
    load_restart = 1'b1;
    @(negedge clk);
    load_restart = 1'b0;
    $display("restart count=%0d run=%0d", load_count, core_run);
    chk("restart_run_low", 32'(core_run), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_known[i] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_ready", 32'(load_ready), 32'd0);
    chk("reset_run",   32'(core_run),   32'd0);
    chk("reset_count", 32'(load_count), 32'd0);
    chk("reset_rdata", 32'(core_rdata), 32'd0);
    rst = 1'b0;

    // Three-word program with last on the third beat.
    send(16'h8105, 1'b0);
    send(16'hA110, 1'b0);
    send(16'hFFFF, 1'b1);
    chk("short_count", 32'(load_count), 32'd3);
    chk("short_run",   32'(core_run),   32'd1);
    chk("short_ready", 32'(load_ready), 32'd0);
    rd(5'd0, 16'h8105);
    rd(5'd1, 16'hA110);
    rd(5'd2, 16'hFFFF);

    // Full 32-word load with last never set; a 33rd beat must be refused.
    restart();
    for (int i = 0; i < 32; i++) send(16'(i), 1'b0);
    chk("full_count", 32'(load_count), 32'd32);
    chk("full_run",   32'(core_run),   32'd1);
    load_valid = 1'b1;
    load_data  = 16'hBEEF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("beat33_ready", 32'(load_ready), 32'd0);
      chk("beat33_count", 32'(load_count), 32'd32);
    end
    load_valid = 1'b0;
    rd(5'd31, 16'h001F);

    // Read-before-write on the same address.
    ram_addr         = 5'd7;
    core_wdata       = 16'h1234;
    ram_write_enable = 1'b1;
    @(negedge clk);
    ram_write_enable = 1'b0;
    chk("rbw_old", 32'(core_rdata), 32'h0007);
    @(negedge clk);
    chk("rbw_new", 32'(core_rdata), 32'h1234);

    // Back-pressured reload with core write attempts that must be ignored.
    restart();
    ram_addr         = 5'd7;
    core_wdata       = 16'hDEAD;
    ram_write_enable = 1'b1;
    send(16'h0A0A, 1'b0);
    @(negedge clk);
    chk("gap_count", 32'(load_count), 32'd1);
    send(16'h0B0B, 1'b0);
    @(negedge clk);
    ram_write_enable = 1'b0;
    send(16'h0C0C, 1'b1);
    chk("bp_count", 32'(load_count), 32'd3);
    rd(5'd0, 16'h0A0A);
    rd(5'd1, 16'h0B0B);
    rd(5'd2, 16'h0C0C);
    rd(5'd7, 16'h1234);
    rd(5'd3, 16'h0003);

    // Single-word reload keeps the upper words.
    restart();
    send(16'h0001, 1'b1);
    chk("one_count", 32'(load_count), 32'd1);
    rd(5'd0, 16'h0001);
    rd(5'd1, 16'h0B0B);

    // Restart colliding with a beat drops the beat.
    restart();
    load_valid   = 1'b1;
    load_data    = 16'h9999;
    load_restart = 1'b1;
    @(negedge clk);
    load_restart = 1'b0;
    load_valid   = 1'b0;
    chk("collide_count", 32'(load_count), 32'd0);

    // Reset in the middle of a load.
    for (int i = 0; i < 5; i++) send(16'h0050 + 16'(i), 1'b0);
    load_valid = 1'b1;
    load_data  = 16'h0055;
    rst        = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 32'(load_ready), 32'd0);
    chk("midrst_run",   32'(core_run),   32'd0);
    chk("midrst_count", 32'(load_count), 32'd0);
    chk("midrst_rdata", 32'(core_rdata), 32'd0);
    rst        = 1'b0;
    load_valid = 1'b0;
    send(16'h7777, 1'b1);
    rd(5'd0, 16'h7777);
    rd(5'd1, 16'h0051);

    // Random traffic, checked cycle by cycle against the model.
    for (int c = 0; c < 600; c++) begin
      rst              = ($urandom_range(0, 79) == 0);
      load_restart     = ($urandom_range(0, 15) == 0);
      load_valid       = $urandom_range(0, 1) == 1;
      load_last        = ($urandom_range(0, 7) == 0);
      load_data        = 16'($urandom);
      ram_addr         = 5'($urandom_range(0, 31));
      ram_write_enable = $urandom_range(0, 1) == 1;
      core_wdata       = 16'($urandom);
      @(negedge clk);
    end
    rst = 1'b0;
    load_valid = 1'b0;
    load_restart = 1'b0;
    ram_write_enable = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
